// File: rtl/updown_counter_seq.sv
// updown_counter_seq: issues load/step commands to an up/down counter
// and checks its final count against the arithmetic prediction.
module updown_counter_seq #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              dir,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [STEP_W-1:0] steps,
  input  logic [PRE_W-1:0]  prescale,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wrapped,
  output logic              err,
  output logic              cnt_load,
  output logic              cnt_enable,
  output logic              cnt_up_down,
  output logic [WIDTH-1:0]  cnt_data,
  input  logic [WIDTH-1:0]  cnt_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PRE_W-1:0]  pcnt_q, pcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              wrapped_q, wrapped_d;
  logic              err_q, err_d;
  logic              cnt_load_q, cnt_load_d;
  logic              cnt_enable_q, cnt_enable_d;
  logic              cnt_up_down_q, cnt_up_down_d;
  logic [WIDTH-1:0]  cnt_data_q, cnt_data_d;

  logic [WIDTH-1:0]  predicted;
  logic              wrap_hit;

  // cnt_data and cnt_up_down hold the captured command for its lifetime
  always_comb begin
    if (cnt_up_down_q) begin
      predicted = cnt_data_q + WIDTH'(steps_q);
    end else begin
      predicted = cnt_data_q - WIDTH'(steps_q);
    end
  end

  assign wrap_hit = cnt_up_down_q ? (cnt_count == '1)
                                  : (cnt_count == '0);

  always_comb begin
    state_d       = state_q;
    steps_d       = steps_q;
    rem_d         = rem_q;
    pre_d         = pre_q;
    pcnt_d        = pcnt_q;
    done_d        = 1'b0;
    result_d      = result_q;
    wrapped_d     = wrapped_q;
    err_d         = err_q;
    cnt_load_d    = 1'b0;
    cnt_enable_d  = 1'b0;
    cnt_up_down_d = cnt_up_down_q;
    cnt_data_d    = cnt_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_LOAD;
          steps_d       = steps;
          pre_d         = prescale;
          wrapped_d     = 1'b0;
          err_d         = 1'b0;
          cnt_load_d    = 1'b1;
          cnt_data_d    = start_val;
          cnt_up_down_d = dir;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          pcnt_d = pre_q;
          rem_d  = steps_q;
          if (steps_q == '0) begin
            state_d = S_SETTLE;
          end else begin
            state_d      = S_RUN;
            cnt_enable_d = (pre_q == '0);
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pcnt_q == '0) begin
          // this cycle carries an enable pulse
          pcnt_d = pre_q;
          rem_d  = rem_q - STEP_W'(1);
          if (wrap_hit) begin
            wrapped_d = 1'b1;
          end
          if (rem_q == STEP_W'(1)) begin
            state_d = S_SETTLE;
          end else begin
            cnt_enable_d = (pre_q == '0);
          end
        end else begin
          pcnt_d       = pcnt_q - PRE_W'(1);
          cnt_enable_d = (pcnt_q == PRE_W'(1));
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          result_d = cnt_count;
          err_d    = (cnt_count != predicted);
          done_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      steps_q       <= '0;
      rem_q         <= '0;
      pre_q         <= '0;
      pcnt_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      wrapped_q     <= 1'b0;
      err_q         <= 1'b0;
      cnt_load_q    <= 1'b0;
      cnt_enable_q  <= 1'b0;
      cnt_up_down_q <= 1'b0;
      cnt_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      steps_q       <= steps_d;
      rem_q         <= rem_d;
      pre_q         <= pre_d;
      pcnt_q        <= pcnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      wrapped_q     <= wrapped_d;
      err_q         <= err_d;
      cnt_load_q    <= cnt_load_d;
      cnt_enable_q  <= cnt_enable_d;
      cnt_up_down_q <= cnt_up_down_d;
      cnt_data_q    <= cnt_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign wrapped     = wrapped_q;
  assign err         = err_q;
  assign cnt_load    = cnt_load_q;
  assign cnt_enable  = cnt_enable_q;
  assign cnt_up_down = cnt_up_down_q;
  assign cnt_data    = cnt_data_q;

endmodule

// File: tb/tb_updown_counter_seq.sv
// tb_updown_counter_seq: random commands against an arithmetic model,
// with a counter stub and a queue-based event monitor.
module tb_updown_counter_seq;
  localparam int W  = 4;
  localparam int SW = 8;
  localparam int PW = 8;
  localparam int M  = 1 << W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dir = 1'b0;
  logic [W-1:0]  start_val = '0;
  logic [SW-1:0] steps = '0;
  logic [PW-1:0] prescale = '0;
  logic          busy, done, wrapped, err;
  logic [W-1:0]  result;
  logic          cnt_load, cnt_enable, cnt_up_down;
  logic [W-1:0]  cnt_data, cnt_count;

  updown_counter_seq #(.WIDTH(W), .STEP_W(SW), .PRE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
    .start_val(start_val), .steps(steps), .prescale(prescale),
    .busy(busy), .done(done), .result(result), .wrapped(wrapped),
    .err(err), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_up_down(cnt_up_down), .cnt_data(cnt_data),
    .cnt_count(cnt_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // counter stub; corrupt_n != 0 adds +1 on that step number
  logic [W-1:0] ctr;
  int en_seen;
  int corrupt_n = 0;
  assign cnt_count = ctr;

  function automatic logic [W-1:0] stub_next(
    input logic [W-1:0] v, input logic up, input logic bump);
    logic [W-1:0] r;
    r = up ? v + W'(1) : v - W'(1);
    if (bump) r = r + W'(1);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= '0;
      en_seen <= 0;
    end else if (cnt_load) begin
      ctr <= cnt_data;
      en_seen <= 0;
    end else if (cnt_enable) begin
      ctr <= stub_next(ctr, cnt_up_down,
                       corrupt_n != 0 && en_seen + 1 == corrupt_n);
      en_seen <= en_seen + 1;
    end
  end

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  typedef struct {
    int cyc;
    int data;
  } ld_t;

  typedef struct {
    int cyc;
    int res;
    int wr;
    int er;
  } dn_t;

  ld_t ld_q[$];
  int  en_q[$];
  dn_t dn_q[$];
  logic cur_dir = 1'b0;
  int last_res = 0;

  function automatic dn_t model(input logic d, input int sv,
    input int n, input int p, input int k, input int bump);
    dn_t r;
    int v;
    v = d ? sv + n : sv - n;
    v = ((v % M) + M) % M;
    if (bump != 0 && n > 0) v = (v + 1) % M;
    r.res = v;
    r.wr  = d ? int'(sv + n >= M) : int'(n > sv);
    r.er  = int'(bump != 0 && n > 0);
    r.cyc = k + 3 + n * (p + 1);
    return r;
  endfunction

  // monitor: every observed event is matched against the queues
  ld_t mld;
  dn_t mdn;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cnt_load && cnt_enable) chk("load_with_enable", 1, 0);
        if (cnt_load) begin
          if (ld_q.size() == 0) begin
            chk("unexpected_load", 1, 0);
          end else begin
            mld = ld_q.pop_front();
            chk("load_cycle", cyc, mld.cyc);
            chk("load_data", int'(cnt_data), mld.data);
            chk("load_dir", int'(cnt_up_down), int'(cur_dir));
          end
        end
        if (cnt_enable) begin
          if (en_q.size() == 0) begin
            chk("unexpected_enable", 1, 0);
          end else begin
            chk("enable_cycle", cyc, en_q.pop_front());
            chk("enable_dir", int'(cnt_up_down), int'(cur_dir));
          end
        end
        if (done) begin
          if (dn_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            mdn = dn_q.pop_front();
            chk("done_cycle", cyc, mdn.cyc);
            chk("result", int'(result), mdn.res);
            chk("wrapped", int'(wrapped), mdn.wr);
            chk("err", int'(err), mdn.er);
            chk("busy_at_done", int'(busy), 1);
          end
        end
      end
    end
  end

  function automatic int out_vec();
    return int'({busy, done, result, wrapped, err,
                 cnt_load, cnt_enable, cnt_up_down, cnt_data});
  endfunction

  task automatic issue(input logic d, input int sv, input int n,
                       input int p, input int bump);
    int k;
    dn_t e;
    @(posedge clk);
    #1;
    corrupt_n = (bump != 0) ? n : 0;
    start = 1'b1;
    dir = d;
    start_val = W'(sv);
    steps = SW'(n);
    prescale = PW'(p);
    cur_dir = d;
    k = cyc;
    e = model(d, sv, n, p, k, bump);
    ld_q.push_back('{cyc: k + 1, data: sv});
    for (int i = 1; i <= n; i++) en_q.push_back(k + 1 + i * (p + 1));
    dn_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    start_val = W'($urandom);
    steps = SW'($urandom);
    for (int t = 0; t < n * (p + 1) + 10 && dn_q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (dn_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      dn_q.delete();
    end
    chk("enables_left", en_q.size(), 0);
    en_q.delete();
    ld_q.delete();
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    last_res = e.res;
    corrupt_n = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #3;
    chk("reset_outputs", out_vec(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", out_vec(), 0);

    issue(1'b1, 4, 3, 0, 0);
    issue(1'b0, 1, 3, 0, 0);
    issue(1'b1, 0, 2, 2, 0);
    issue(1'b1, 9, 0, 0, 0);
    issue(1'b0, 9, 0, 3, 0);

    // start together with abort is not accepted
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    start_val = W'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_result", int'(result), last_res);

    // abort after the first of five steps; a start while busy is ignored
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b1;
    dir = 1'b1;
    cur_dir = 1'b1;
    start_val = W'(2);
    steps = SW'(5);
    prescale = PW'(2);
    ld_q.push_back('{cyc: k + 1, data: 2});
    en_q.push_back(k + 4);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b1;
    start_val = W'(9);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("busy_before_abort", int'(busy), 1);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("busy_after_abort", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("abort_enables_left", en_q.size(), 0);
    chk("abort_loads_left", ld_q.size(), 0);
    chk("abort_result_held", int'(result), last_res);
    chk("abort_count", int'(cnt_count), 3);
    en_q.delete();
    ld_q.delete();

    issue(1'b1, 4, 3, 0, 1);
    issue(1'b0, 1, 3, 1, 1);

    // reset in the middle of a running command
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b1;
    dir = 1'b0;
    cur_dir = 1'b0;
    start_val = W'(7);
    steps = SW'(10);
    prescale = PW'(1);
    ld_q.push_back('{cyc: k + 1, data: 7});
    for (int i = 1; i <= 10; i++) en_q.push_back(k + 1 + i * 2);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs", out_vec(), 0);
    en_q.delete();
    ld_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_outputs", out_vec(), 0);

    for (int r = 0; r < 30; r++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/updown_counter_seq.md
Name: updown_counter_seq

Overview:
Command-driven sequencer that drives the control port of the team's WIDTH-bit up/down counter (load, enable, up_down, data_in) and observes its count_out. A single start command loads a start value and issues a programmed number of count steps at a programmed rate. On completion it reports the final count, whether a wrap occurred, and whether the counter's result matched the internally predicted value. It is the initiator side of the counter interface and sits between lab control logic and the counter instance.

Parameters:
WIDTH, 4, counter data width; must match the driven counter
STEP_W, 8, width of the step-count field
PRE_W, 8, width of the prescale field

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe, sampled only in IDLE
abort  in  1  cancel the active command
dir  in  1  1 = count up, 0 = count down; captured on start
start_val  in  WIDTH  value loaded into counter; captured on start
steps  in  STEP_W  number of count steps N; captured on start
prescale  in  PRE_W  idle cycles P between enable pulses; captured on start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
result  out  WIDTH  counter value captured at completion
wrapped  out  1  a step crossed all-ones->0 (up) or 0->all-ones (down)
err  out  1  final counter value != predicted value
cnt_load  out  1  to counter load
cnt_enable  out  1  to counter enable
cnt_up_down  out  1  to counter up_down
cnt_data  out  WIDTH  to counter data_in
cnt_count  in  WIDTH  from counter count_out

Behaviour:
- Reset (async, active-high): state IDLE; busy, done, wrapped, err, cnt_load, cnt_enable = 0; result, cnt_data = 0; cnt_up_down = 0; internal counters cleared. Applies mid-command with no done pulse.
- All outputs registered. States: IDLE, LOAD, RUN, SETTLE, DONE.
- IDLE: on start=1 and abort=0, capture dir/start_val/steps/prescale, clear wrapped and err, go to LOAD. start while not IDLE is ignored. start and abort together in IDLE: command is not accepted.
- LOAD (1 cycle): cnt_load=1, cnt_data=start_val, cnt_up_down=dir. Prescale counter := P; remaining := N. If N=0, go to SETTLE; otherwise go to RUN.
- RUN: each cycle, if prescale counter = 0, assert cnt_enable for that cycle, reload P, and decrement remaining; otherwise decrement the prescale counter. On an enable cycle, set wrapped if (dir=1 and cnt_count = all-ones) or (dir=0 and cnt_count = 0). After the enable cycle that makes remaining 0, go to SETTLE.
- cnt_enable is never high in the same cycle as cnt_load. cnt_up_down is held at dir for the whole command.
- SETTLE (1 cycle): the counter has absorbed its last update. Latch result := cnt_count. Set err := (cnt_count != predicted), where predicted = (start_val + N) mod 2^WIDTH if dir=1, and (start_val - N) mod 2^WIDTH if dir=0. Go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. result, wrapped, and err hold until the next accepted start.
- Timing, with start sampled at edge k: cnt_load high in cycle k+1. The i-th enable pulse (i=1..N) occurs in cycle k+1+i(P+1). SETTLE occurs in cycle k+2+N(P+1). done is high in cycle k+3+N(P+1).
- abort=1 in LOAD, RUN, or SETTLE: go to IDLE at the next edge. cnt_load and cnt_enable are 0 from that cycle on. No done pulse. result is unchanged.
- Wrap counting: N may exceed 2^WIDTH; wrapped is set on any qualifying step, and the arithmetic is modulo 2^WIDTH.

Test Plan:
- WIDTH=4, dir=1, start_val=4, steps=3, P=0 -> cnt_load in cycle k+1, cnt_enable in cycles k+2..k+4, done in cycle k+6, result=7, wrapped=0, err=0.
- dir=0, start_val=1, steps=3, P=0 -> counter sequence 1,0,15,14; result=14, wrapped=1, err=0.
- dir=1, start_val=0, steps=2, P=2 -> enable pulses only in cycles k+4 and k+7; done in cycle k+9; result=2.
- steps=0, start_val=9 -> one load cycle, no enables, done in cycle k+3, result=9, wrapped=0, err=0.
- abort during RUN after the 1st of 5 steps -> busy drops next cycle, no further enables, no done pulse; a second start while busy is ignored (no reload).
- counter stub forced to return value+1 on the final step -> err=1 with done; then assert rst mid-RUN on a later command -> all outputs 0 immediately.
